// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline register with 2-entry skid buffer, flush and bubble ctrl zeroing
module pipe_stage_skid #(
  parameter int DATA_W              = 69,
  parameter int CTRL_W              = 4,
  parameter bit ZERO_CTRL_ON_BUBBLE = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occupancy_o
);

  // Encoding equals the number of held entries so occupancy_o is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic in_fire;
  logic out_fire;

  assign valid_o     = (state_q != ST_EMPTY);
  assign ready_o     = (state_q != ST_SKID);
  assign occupancy_o = state_q;
  assign data_o      = main_data_q;

  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  generate
    if (ZERO_CTRL_ON_BUBBLE) begin : g_zero_ctrl
      assign ctrl_o = valid_o ? main_ctrl_q : '0;
    end else begin : g_raw_ctrl
      assign ctrl_o = main_ctrl_q;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    // Flush only invalidates; payload registers keep their contents.
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_ctrl_d = ctrl_i;
            main_data_d = data_i;
            state_d     = ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = ctrl_i;
            main_data_d = data_i;
          end else if (in_fire) begin
            skid_ctrl_d = ctrl_i;
            skid_data_d = data_i;
            state_d     = ST_SKID;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - randomized bench for pipe_stage_skid against a queue model
module tb_pipe_stage_skid;
  localparam int DW = 69;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [CW-1:0] ctrl_i = '0;
  logic [DW-1:0] data_i = '0;

  logic          ready_o, valid_o, ready_o_nz, valid_o_nz;
  logic [CW-1:0] ctrl_o, ctrl_o_nz;
  logic [DW-1:0] data_o, data_o_nz;
  logic [1:0]    occ_o, occ_o_nz;

  int total = 0;
  int bad   = 0;

  // Model: FIFO of {ctrl,data} holding at most two entries, plus last presented entry.
  logic [CW+DW-1:0] mq[$];
  logic [CW+DW-1:0] last_main = '0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .ZERO_CTRL_ON_BUBBLE(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_i), .ready_o(ready_o),
    .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i),
    .ctrl_o(ctrl_o), .data_o(data_o), .occupancy_o(occ_o)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .ZERO_CTRL_ON_BUBBLE(1'b0)) u_dut_nz (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_i), .ready_o(ready_o_nz),
    .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(valid_o_nz), .ready_i(ready_i),
    .ctrl_o(ctrl_o_nz), .data_o(data_o_nz), .occupancy_o(occ_o_nz)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic          mv;
    logic [CW-1:0] mc;
    mv = (mq.size() > 0);
    mc = last_main[CW+DW-1:DW];
    check("valid_o", valid_o, mv);
    check("ready_o", ready_o, mq.size() < 2);
    check("occupancy_o", occ_o, mq.size());
    check("data_o", data_o, last_main[DW-1:0]);
    check("ctrl_o", ctrl_o, mv ? mc : '0);
    check("nz_valid_o", valid_o_nz, mv);
    check("nz_occupancy_o", occ_o_nz, mq.size());
    check("nz_data_o", data_o_nz, last_main[DW-1:0]);
    check("nz_ctrl_o", ctrl_o_nz, mc);
  endtask

  task automatic model_reset();
    mq.delete();
    last_main = '0;
  endtask

  // One clock: evaluate handshakes from pre-edge state, advance model, check at edge+1.
  task automatic step();
    bit in_f, out_f;
    in_f  = valid_i && (mq.size() < 2);
    out_f = (mq.size() > 0) && ready_i;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (flush) begin
      mq.delete();
    end else begin
      if (out_f) void'(mq.pop_front());
      if (in_f) mq.push_back({ctrl_i, data_i});
      if (mq.size() > 0) last_main = mq[0];
    end
    #1;
    compare_all();
  endtask

  task automatic drive(input logic v, input logic r, input logic [CW-1:0] c, input logic [DW-1:0] d);
    valid_i = v;
    ready_i = r;
    ctrl_i  = c;
    data_i  = d;
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 compare_all();
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("idle_occ", occ_o, 2'd0);

    // Streaming at full rate
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 4'h5, DW'(8'h10 + i));
      step();
      check("stream_data", data_o, DW'(8'h10 + i));
      check("stream_occ", occ_o, 2'd1);
    end

    // Back-pressure fills the skid entry, then drains in order
    drive(1'b1, 1'b0, 4'h3, DW'(8'h20));
    step();
    drive(1'b1, 1'b0, 4'h3, DW'(8'h21));
    step();
    drive(1'b1, 1'b0, 4'h3, DW'(8'h22));
    step();
    check("skid_occ", occ_o, 2'd2);
    check("skid_ready", ready_o, 1'b0);
    drive(1'b1, 1'b1, 4'h3, DW'(8'h22));
    step();
    drive(1'b0, 1'b1, 4'h0, '0);
    step();
    step();
    step();

    // Flush while in SKID with a simultaneous input
    drive(1'b1, 1'b0, 4'h6, DW'(8'h30));
    step();
    step();
    flush = 1'b1;
    drive(1'b1, 1'b0, 4'hA, DW'(8'h33));
    step();
    flush = 1'b0;
    drive(1'b0, 1'b1, 4'h0, '0);
    check("flush_occ", occ_o, 2'd0);
    check("flush_ctrl", ctrl_o, 4'h0);
    check("flush_ready", ready_o, 1'b1);
    step();
    step();

    // Bubble zeroing
    drive(1'b1, 1'b1, 4'hF, DW'(8'h44));
    step();
    check("bubble_ctrl_valid", ctrl_o, 4'hF);
    drive(1'b0, 1'b1, 4'h0, '0);
    step();
    check("bubble_ctrl_zero", ctrl_o, 4'h0);
    check("bubble_ctrl_raw", ctrl_o_nz, 4'hF);
    check("bubble_data_hold", data_o, DW'(8'h44));

    // Asynchronous reset mid-SKID
    drive(1'b1, 1'b0, 4'h9, DW'(8'h55));
    step();
    step();
    check("pre_reset_occ", occ_o, 2'd2);
    #2 rst = 1'b1;
    model_reset();
    #1 compare_all();
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'h0, '0);
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, CW'($urandom),
            {DW'($urandom), 32'($urandom), 32'($urandom)});
      flush = ($urandom_range(0, 29) == 0);
      step();
    end
    flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised inter-stage pipeline register (successor to the fixed-field stage registers, e.g. EX/MEM) with a valid/ready handshake.
- Adds a 2-entry skid buffer, per-stage flush, and bubble control-zeroing.
- Sits between any two pipeline stages. Control bits (RegWrite, MemRead, ...) and datapath fields (ALU result, store data, rd) are packed into ctrl/data buses.
- Back-pressure can stall upstream without a combinational ready path.

Parameters:
- DATA_W, 69, packed datapath width (e.g. 32 ALU result + 32 store data + 5 rd).
- CTRL_W, 4, packed control width (RegWrite, MemtoReg, MemRead, MemWrite).
- ZERO_CTRL_ON_BUBBLE, 1, when 1, ctrl_o is forced to 0 whenever valid_o=0.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous flush: discard all held entries.
- valid_i  in  1  upstream entry valid.
- ready_o  out  1  stage can accept; registered (depends only on state).
- ctrl_i  in  CTRL_W  upstream control bits.
- data_i  in  DATA_W  upstream datapath bits.
- valid_o  out  1  output entry valid.
- ready_i  in  1  downstream accepts.
- ctrl_o  out  CTRL_W  output control bits.
- data_o  out  DATA_W  output datapath bits.
- occupancy_o  out  2  entries held: 0, 1 or 2.

Behaviour:
- Storage: main entry (drives outputs) and skid entry. Both are {ctrl, data} plus an implied valid.
- Handshakes: in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
- States: EMPTY (occ 0), FULL (occ 1, main valid), SKID (occ 2, main+skid valid).
- Outputs: valid_o = (state != EMPTY); ready_o = (state != SKID); occupancy_o encodes state.
- EMPTY: valid_i -> load main, go FULL. Otherwise stay.
- FULL:
  - in_fire & out_fire -> main <= input, stay FULL.
  - in_fire & !ready_i -> skid <= input, go SKID.
  - !valid_i & ready_i -> go EMPTY.
  - Otherwise hold.
- SKID: inputs ignored (ready_o=0). ready_i -> main <= skid, go FULL. Otherwise hold both entries.
- Ordering: strict FIFO; no entry is dropped or duplicated except by flush/reset.
- Latency: 1 cycle from in_fire to valid_o when EMPTY. Throughput 1 entry/cycle while ready_i=1.
- flush_i: next edge -> EMPTY, both entries invalid, regardless of valid_i/ready_i.
  - A simultaneous in_fire is discarded (flush wins).
  - The current output's out_fire in that cycle still counts downstream; the block does not re-present that entry.
- Bubble zeroing: if ZERO_CTRL_ON_BUBBLE=1 and valid_o=0, ctrl_o = 0. This holds combinationally during reset and after flush.
- Data outputs: data_o always reflects main data. Main/skid data regs are not cleared on flush, only on reset.
- Reset (rst_i=1, asynchronous): state EMPTY; main and skid ctrl/data = 0.
  - Outputs during and after reset: valid_o=0, ctrl_o=0, data_o=0, occupancy_o=0, ready_o=1.
  - Handshakes while rst_i=1 have no effect.
  - Reset asserted mid-SKID drops both entries immediately, without waiting for a clock.
- Release: first state update on the first rising edge with rst_i=0.
- Widths: pure storage, no arithmetic. All buses pass bit-exact.

Test Plan:
- Reset: rst_i=1 asynchronously while in SKID -> within the same cycle valid_o=0, ctrl_o=0, data_o=0, occupancy_o=0, ready_o=1. After release, stays EMPTY with no input.
- Streaming: ready_i=1, data_i = 0x10, 0x11, 0x12 on consecutive cycles with valid_i=1 -> data_o = 0x10, 0x11, 0x12 one cycle later each. occupancy_o stays 1; ready_o stays 1.
- Back-pressure/skid:
  - ready_i=0 while sending A=0x20 then B=0x21 -> occupancy_o goes 1 then 2, ready_o=0, C=0x22 held upstream.
  - Raise ready_i -> outputs A, B, C in order, none lost.
- Flush: in SKID, assert flush_i with valid_i=1, data_i=0x33 -> next cycle occupancy_o=0, valid_o=0, ctrl_o=0, ready_o=1. 0x33 never appears on the output.
- Bubble zeroing: ctrl_i=4'b1111 for one entry, then valid_i=0 -> ctrl_o=4'b1111 for one cycle, then 4'b0000 while data_o holds the last data.
- ZERO_CTRL_ON_BUBBLE=0 with the same stimulus -> ctrl_o holds 4'b1111 after valid_o drops.
